kvadd2_axis_stream_source: RTL and testbench

- AXI4-Stream transmitter producing the input stream for the kernel's pipelined lane adder (master side of that adder's s_axis).
- A one-cycle start command loads a beat count and a base value.
- The block emits that many full-width beats of incrementing lane values, marks the final beat with tlast, and pulses done.
- Used as the kernel's internal traffic source and as the stimulus end in system test builds.

---
 rtl/kvadd2_axis_stream_source.sv | 137 +++++++++++++
 tb/tb_kvadd2_axis_stream_source.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/kvadd2_axis_stream_source.sv
// AXI4-Stream source: on a start command emits `length` beats of incrementing
// per-lane values from `base`, flags the final beat with tlast and pulses done.
module kvadd2_axis_stream_source #(
   parameter int C_AXIS_TDATA_WIDTH = 512,
   parameter int C_ADDER_BIT_WIDTH  = 32,
   parameter int C_LENGTH_WIDTH     = 32
) (
   input  logic                            m_axis_aclk,
   input  logic                            m_axis_aresetn,
   input  logic                            ctrl_start,
   input  logic [C_LENGTH_WIDTH-1:0]       ctrl_length,
   input  logic [C_ADDER_BIT_WIDTH-1:0]    ctrl_base,
   output logic                            ctrl_busy,
   output logic                            ctrl_done,
   output logic                            m_axis_tvalid,
   input  logic                            m_axis_tready,
   output logic [C_AXIS_TDATA_WIDTH-1:0]   m_axis_tdata,
   output logic [C_AXIS_TDATA_WIDTH/8-1:0] m_axis_tkeep,
   output logic [C_AXIS_TDATA_WIDTH/8-1:0] m_axis_tstrb,
   output logic                            m_axis_tlast
);

   localparam int LANES = C_AXIS_TDATA_WIDTH / C_ADDER_BIT_WIDTH;
   localparam int KEEPW = C_AXIS_TDATA_WIDTH / 8;
   localparam logic [C_ADDER_BIT_WIDTH-1:0] LANE_STEP = C_ADDER_BIT_WIDTH'(LANES);

   typedef enum logic {
      S_IDLE,
      S_RUN
   } state_t;

   state_t                          r_state, w_stateNext;
   logic [C_AXIS_TDATA_WIDTH-1:0]   r_data, w_dataNext;
   logic [C_LENGTH_WIDTH-1:0]       r_count, w_countNext;
   logic [C_LENGTH_WIDTH-1:0]       r_lastIdx, w_lastIdxNext;
   logic [KEEPW-1:0]                r_keep, w_keepNext;
   logic                            r_valid, w_validNext;
   logic                            r_last, w_lastNext;
   logic                            r_busy, w_busyNext;
   logic                            r_done, w_doneNext;
   logic                            w_handshake;

   assign w_handshake = r_valid & m_axis_tready;

   // Next-state logic; lanes are seeded with base+i and step by LANES per beat,
   // each lane wrapping on its own with no carry into its neighbour.
   always_comb begin
      w_stateNext   = r_state;
      w_dataNext    = r_data;
      w_countNext   = r_count;
      w_lastIdxNext = r_lastIdx;
      w_keepNext    = r_keep;
      w_validNext   = r_valid;
      w_lastNext    = r_last;
      w_busyNext    = r_busy;
      w_doneNext    = 1'b0;

      case (r_state)
         S_IDLE: begin
            if (ctrl_start) begin
               if (ctrl_length != '0) begin
                  w_stateNext   = S_RUN;
                  w_countNext   = '0;
                  w_lastIdxNext = ctrl_length - C_LENGTH_WIDTH'(1);
                  w_validNext   = 1'b1;
                  w_busyNext    = 1'b1;
                  w_lastNext    = (ctrl_length == C_LENGTH_WIDTH'(1));
                  w_keepNext    = '1;
                  for (int i = 0; i < LANES; i++) begin
                     w_dataNext[i*C_ADDER_BIT_WIDTH +: C_ADDER_BIT_WIDTH] =
                        ctrl_base + C_ADDER_BIT_WIDTH'(i);
                  end
               end else begin
                  w_doneNext = 1'b1;
               end
            end
         end

         S_RUN: begin
            if (w_handshake) begin
               if (r_count == r_lastIdx) begin
                  w_stateNext = S_IDLE;
                  w_validNext = 1'b0;
                  w_lastNext  = 1'b0;
                  w_busyNext  = 1'b0;
                  w_keepNext  = '0;
                  w_doneNext  = 1'b1;
               end else begin
                  w_countNext = r_count + C_LENGTH_WIDTH'(1);
                  w_lastNext  = ((r_count + C_LENGTH_WIDTH'(1)) == r_lastIdx);
                  for (int i = 0; i < LANES; i++) begin
                     w_dataNext[i*C_ADDER_BIT_WIDTH +: C_ADDER_BIT_WIDTH] =
                        r_data[i*C_ADDER_BIT_WIDTH +: C_ADDER_BIT_WIDTH] + LANE_STEP;
                  end
               end
            end
         end

         default: begin
            w_stateNext = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
      if (!m_axis_aresetn) begin
         r_state   <= S_IDLE;
         r_data    <= '0;
         r_count   <= '0;
         r_lastIdx <= '0;
         r_keep    <= '0;
         r_valid   <= 1'b0;
         r_last    <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         r_state   <= w_stateNext;
         r_data    <= w_dataNext;
         r_count   <= w_countNext;
         r_lastIdx <= w_lastIdxNext;
         r_keep    <= w_keepNext;
         r_valid   <= w_validNext;
         r_last    <= w_lastNext;
         r_busy    <= w_busyNext;
         r_done    <= w_doneNext;
      end
   end

   assign m_axis_tvalid = r_valid;
   assign m_axis_tdata  = r_data;
   assign m_axis_tlast  = r_last;
   assign m_axis_tkeep  = r_keep;
   assign m_axis_tstrb  = r_keep;
   assign ctrl_busy     = r_busy;
   assign ctrl_done     = r_done;

endmodule

// File: tb/tb_kvadd2_axis_stream_source.sv
// Scoreboard bench for kvadd2_axis_stream_source: directed scenarios plus
// randomized packets with random backpressure, checked by a monitor process.
module tb_kvadd2_axis_stream_source;

   localparam int D     = 512;
   localparam int W     = 32;
   localparam int L     = 32;
   localparam int LANES = D / W;
   localparam int KW    = D / 8;

   typedef struct {
      logic [D-1:0] data;
      logic         last;
   } beat_t;

   logic          clk = 1'b0;
   logic          aresetn = 1'b0;
   logic          ctrl_start = 1'b0;
   logic [L-1:0]  ctrl_length = '0;
   logic [W-1:0]  ctrl_base = '0;
   logic          ctrl_busy, ctrl_done;
   logic          tvalid, tlast;
   logic          tready = 1'b1;
   logic [D-1:0]  tdata;
   logic [KW-1:0] tkeep, tstrb;

   beat_t expQ[$];
   bit    readyQ[$];
   bit    readyRandom = 1'b0;
   bit    zeroStart = 1'b0;
   int    hsCount = 0;
   int    checks = 0;
   int    failures = 0;

   kvadd2_axis_stream_source #(
      .C_AXIS_TDATA_WIDTH (D),
      .C_ADDER_BIT_WIDTH  (W),
      .C_LENGTH_WIDTH     (L)
   ) dut (
      .m_axis_aclk    (clk),
      .m_axis_aresetn (aresetn),
      .ctrl_start     (ctrl_start),
      .ctrl_length    (ctrl_length),
      .ctrl_base      (ctrl_base),
      .ctrl_busy      (ctrl_busy),
      .ctrl_done      (ctrl_done),
      .m_axis_tvalid  (tvalid),
      .m_axis_tready  (tready),
      .m_axis_tdata   (tdata),
      .m_axis_tkeep   (tkeep),
      .m_axis_tstrb   (tstrb),
      .m_axis_tlast   (tlast)
   );

   initial forever #5 clk = ~clk;

   // Reference: lane i of beat k is base + k*LANES + i, wrapped to W bits.
   function automatic logic [D-1:0] modelBeat(input logic [W-1:0] base, input int k);
      logic [D-1:0] v;
      v = '0;
      for (int i = 0; i < LANES; i++) v[i*W +: W] = base + W'(k * LANES + i);
      return v;
   endfunction

   task automatic checkOutput(input string name, input logic [D-1:0] act, input logic [D-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input int len, input logic [W-1:0] base, input bit expectAccept);
      beat_t b;
      ctrl_length = L'(len);
      ctrl_base   = base;
      ctrl_start  = 1'b1;
      zeroStart   = expectAccept && (len == 0);
      if (expectAccept) begin
         for (int k = 0; k < len; k++) begin
            b.data = modelBeat(base, k);
            b.last = (k == len - 1);
            expQ.push_back(b);
         end
      end
      @(posedge clk);
      #1;
      ctrl_start = 1'b0;
      zeroStart  = 1'b0;
   endtask

   task automatic waitDone(input string name);
      int n = 0;
      while (!ctrl_done && n < 500) begin
         @(posedge clk);
         #1;
         n++;
      end
      checkOutput({name, "_done_timeout"}, D'(ctrl_done), D'(1));
   endtask

   task automatic measureBusy(output int n);
      n = 0;
      while (ctrl_busy && n < 500) begin
         n++;
         @(posedge clk);
         #1;
      end
   endtask

   // tready driver: explicit pattern first, then random or held high.
   initial forever begin
      @(posedge clk);
      #2;
      if (readyQ.size() > 0) tready = readyQ.pop_front();
      else if (readyRandom)  tready = 1'($urandom_range(0, 1));
      else                   tready = 1'b1;
   end

   // Monitor: samples mid-cycle, pops the scoreboard on every handshake and
   // checks AXIS stability, keep/strb, busy and the done pulse timing.
   initial begin
      logic [D-1:0] prevData;
      logic         prevValid, prevReady, prevLast, prevFinalHs, prevZeroStart;
      logic [KW-1:0] ones;
      beat_t        e;
      ones = '1;
      prevData = '0; prevValid = 0; prevReady = 0; prevLast = 0;
      prevFinalHs = 0; prevZeroStart = 0;
      forever begin
         @(negedge clk);
         if (!aresetn) begin
            prevValid = 0; prevFinalHs = 0; prevZeroStart = 0;
         end else begin
            checkOutput("tkeep", D'(tkeep), tvalid ? D'(ones) : D'(0));
            checkOutput("tstrb", D'(tstrb), tvalid ? D'(ones) : D'(0));
            checkOutput("busy_vs_valid", D'(ctrl_busy), D'(tvalid));
            checkOutput("done_pulse", D'(ctrl_done), D'(prevFinalHs | prevZeroStart));
            if (prevValid && !prevReady) begin
               checkOutput("hold_valid", D'(tvalid), D'(1));
               checkOutput("hold_data", tdata, prevData);
               checkOutput("hold_last", D'(tlast), D'(prevLast));
            end
            if (tvalid && tready) begin
               hsCount++;
               if (expQ.size() == 0) begin
                  checkOutput("unexpected_beat", D'(1), D'(0));
               end else begin
                  e = expQ.pop_front();
                  checkOutput("beat_data", tdata, e.data);
                  checkOutput("beat_last", D'(tlast), D'(e.last));
               end
            end
            prevData      = tdata;
            prevValid     = tvalid;
            prevReady     = tready;
            prevLast      = tlast;
            prevFinalHs   = tvalid & tready & tlast;
            prevZeroStart = zeroStart;
         end
      end
   end

   initial begin
      #2_000_000;
      failures++;
      $display("[TB] FAIL watchdog actual=running expected=finished");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      int n, hs0;
      logic [W-1:0] rb;
      int rl;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      checkOutput("rst_tvalid", D'(tvalid), D'(0));
      checkOutput("rst_tlast", D'(tlast), D'(0));
      checkOutput("rst_tdata", tdata, D'(0));
      checkOutput("rst_tkeep", D'(tkeep), D'(0));
      checkOutput("rst_busy", D'(ctrl_busy), D'(0));
      checkOutput("rst_done", D'(ctrl_done), D'(0));
      aresetn = 1'b1;
      @(posedge clk);
      #1;

      // 1: four beats at full throughput
      applyStimulus(4, 32'd0, 1'b1);
      checkOutput("t1_latency", D'(tvalid), D'(1));
      checkOutput("t1_b0_lane15", D'(tdata[15*W +: W]), D'(15));
      measureBusy(n);
      checkOutput("t1_busy_cycles", D'(n), D'(4));
      checkOutput("t1_done", D'(ctrl_done), D'(1));
      @(posedge clk);
      #1;

      // 2: backpressure pattern
      hs0 = hsCount;
      applyStimulus(3, 32'd100, 1'b1);
      readyQ.push_back(0); readyQ.push_back(1); readyQ.push_back(0);
      readyQ.push_back(0); readyQ.push_back(1); readyQ.push_back(1);
      waitDone("t2");
      checkOutput("t2_handshakes", D'(hsCount - hs0), D'(3));
      @(posedge clk);
      #1;

      // 3: zero-length command
      applyStimulus(0, 32'd9, 1'b1);
      checkOutput("t3_tvalid", D'(tvalid), D'(0));
      checkOutput("t3_done", D'(ctrl_done), D'(1));
      checkOutput("t3_busy", D'(ctrl_busy), D'(0));
      @(posedge clk);
      #1;
      checkOutput("t3_done_once", D'(ctrl_done), D'(0));

      // 4: per-lane wrap on a single beat
      applyStimulus(1, 32'hFFFF_FFF8, 1'b1);
      checkOutput("t4_tlast", D'(tlast), D'(1));
      checkOutput("t4_lane7", D'(tdata[7*W +: W]), D'(32'hFFFF_FFFF));
      checkOutput("t4_lane8", D'(tdata[8*W +: W]), D'(32'h0000_0000));
      checkOutput("t4_lane15", D'(tdata[15*W +: W]), D'(32'h0000_0007));
      waitDone("t4");
      @(posedge clk);
      #1;

      // 5: start during RUN ignored; start in the done cycle accepted
      applyStimulus(2, 32'h10, 1'b1);
      applyStimulus(7, 32'd999, 1'b0);
      waitDone("t5a");
      applyStimulus(1, 32'd5, 1'b1);
      checkOutput("t5_b2b_valid", D'(tvalid), D'(1));
      checkOutput("t5_b2b_lane0", D'(tdata[W-1:0]), D'(5));
      waitDone("t5b");
      @(posedge clk);
      #1;

      // 6: asynchronous reset mid-packet
      hs0 = hsCount;
      applyStimulus(5, 32'd200, 1'b1);
      n = 0;
      while (hsCount < hs0 + 2 && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      checkOutput("t6_two_hs", D'(hsCount - hs0), D'(2));
      #2;
      aresetn = 1'b0;
      #1;
      checkOutput("t6_async_tvalid", D'(tvalid), D'(0));
      checkOutput("t6_async_tlast", D'(tlast), D'(0));
      checkOutput("t6_async_busy", D'(ctrl_busy), D'(0));
      checkOutput("t6_async_done", D'(ctrl_done), D'(0));
      expQ.delete();
      repeat (2) @(posedge clk);
      #1;
      aresetn = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("t6_no_done", D'(ctrl_done), D'(0));
      applyStimulus(1, 32'd7, 1'b1);
      checkOutput("t6_fresh_valid", D'(tvalid), D'(1));
      waitDone("t6");
      @(posedge clk);
      #1;

      // Randomized packets under random backpressure
      readyRandom = 1'b1;
      for (int p = 0; p < 25; p++) begin
         rl = $urandom_range(0, 9);
         rb = $urandom;
         applyStimulus(rl, rb, 1'b1);
         waitDone("rand");
         @(posedge clk);
         #1;
      end
      readyRandom = 1'b0;
      repeat (3) @(posedge clk);
      #1;

      checkOutput("scoreboard_empty", D'(expQ.size()), D'(0));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
